gpr_writeback: RTL and testbench
================================

Name: gpr_writeback

Overview:
- Writer-side companion of the 2R/1W general purpose register file.
- Arbitrates results from three producers onto the single register-file write port:
  - ALU: single-cycle, no backpressure.
  - Load/store unit (LSU): valid/ready.
  - Multiply/divide unit (MDU): valid/ready.
- Keeps a busy scoreboard of destination registers with pending long-latency results, so issue can stall on RAW/WAW hazards.
- Sits between the execute/memory units and the register file. Its rd/rrd/we outputs drive the register file's write port directly.

Parameters:
- XLEN, 32, data width of results and of rrd.
- RR_SLOW, 1, 1 = round-robin between LSU and MDU; 0 = fixed priority, LSU over MDU.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_rd  input  5  ALU destination.
- alu_res  input  XLEN  ALU result.
- lsu_valid  input  1  load result offered.
- lsu_ready  output  1  load result accepted this cycle.
- lsu_rd  input  5  load destination.
- lsu_res  input  XLEN  load data.
- mdu_valid  input  1  mul/div result offered.
- mdu_ready  output  1  mul/div result accepted this cycle.
- mdu_rd  input  5  mul/div destination.
- mdu_res  input  XLEN  mul/div result.
- busy_set  input  1  issue stage dispatched a long-latency op.
- busy_rd  input  5  destination of that op.
- q_rs1  input  5  scoreboard query 1.
- q_rs2  input  5  scoreboard query 2.
- q_rd  input  5  scoreboard query 3 (WAW check).
- busy_rs1  output  1  q_rs1 has a pending write.
- busy_rs2  output  1  q_rs2 has a pending write.
- busy_qrd  output  1  q_rd has a pending write.
- rd  output  5  register-file write address.
- rrd  output  XLEN  register-file write data.
- we  output  1  register-file write enable.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - we=0, rd=0, rrd=0.
  - Busy vector cleared to all zeros.
  - Round-robin pointer set to LSU.
  - lsu_ready and mdu_ready are 0 while rst=1.
  - An in-flight handshake offered during reset is not accepted and not written.
- Arbitration (combinational grant, evaluated each cycle):
  - ALU has absolute priority. If alu_valid=1, then lsu_ready=0 and mdu_ready=0.
  - Otherwise, with one slow source valid, that source gets ready=1.
  - With both slow sources valid: RR_SLOW=1 grants the source the pointer names; RR_SLOW=0 always grants LSU.
  - The pointer toggles to the other source after each accepted LSU/MDU transfer.
  - ready never depends on ready. A valid source must hold its rd/res stable until ready=1.
- Output register (1-cycle latency):
  - At the edge following a grant, rd and rrd take the winner's destination and data.
  - we=1 iff a source was granted and its destination != 0.
  - With no grant, we=0; rd and rrd hold their previous values.
  - Invariant: we=1 never occurs with rd=0.
  - Transfers with destination 0 are consumed: ready=1, the scoreboard is untouched, and no write occurs.
- Scoreboard (32-bit busy vector; bit 0 is constant 0):
  - busy_set with busy_rd!=0 sets that bit at the clock edge.
  - An accepted LSU/MDU transfer clears the bit of its destination at the same edge that loads the output register.
  - So when we=1 is visible for a slow result, busy for that register is already 0. The register file's same-cycle bypass supplies the value.
  - An ALU write does not touch the busy vector.
  - Simultaneous set and clear of the same register: set wins, and the bit stays 1.
- busy_rs1, busy_rs2 and busy_qrd are combinational reads of the busy vector. Query of register 0 returns 0.
- An ALU write to a busy register is a producer error: it is written and the busy bit is unchanged. The bench flags it with an assertion.
- Throughput: one write per cycle. A slow source stalls only while the ALU is valid or the other slow source holds priority.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> we=0, rd=0, rrd=0, all busy outputs 0, lsu_ready=mdu_ready=0 during reset.
- ALU write: alu_valid=1, alu_rd=5, alu_res=0x12345678 -> next cycle we=1, rd=5, rrd=0x12345678. With lsu_valid=1 in the same cycle, lsu_ready=0; the LSU is accepted the following cycle.
- Scoreboard round trip: busy_set rd=7 -> busy_rs1 (q_rs1=7) =1 next cycle. mdu_valid, mdu_rd=7, res=0xDEADBEEF -> mdu_ready=1; next cycle busy_rs1=0 while we=1, rd=7, rrd=0xDEADBEEF.
- Round-robin: lsu_valid and mdu_valid held 4 cycles, RR_SLOW=1, ALU idle -> grants LSU, MDU, LSU, MDU. With RR_SLOW=0 -> all four grants go to LSU.
- Zero destination: lsu_valid=1, lsu_rd=0, res=0xFFFFFFFF -> lsu_ready=1, next cycle we=0, and the busy vector is unchanged.
- Simultaneous set/clear and mid-operation reset: busy_set rd=9 in the same cycle an LSU transfer to 9 is accepted -> busy[9] stays 1. rst asserted while mdu_valid=1 -> no ready and no write; all busy bits 0 after reset.

Source files
------------

// File: rtl/gpr_writeback.sv
// Writeback arbiter for the 2R/1W register file: merges ALU, LSU and MDU results onto the
// single write port and tracks registers that still have a long-latency write pending.
module gpr_writeback #(
  parameter int XLEN    = 32,
  parameter int RR_SLOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_res,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_res,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_res,
  input  logic            busy_set,
  input  logic [4:0]      busy_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  input  logic [4:0]      q_rd,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            busy_qrd,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rrd,
  output logic            we
);

  typedef enum logic {
    SRC_LSU = 1'b0,
    SRC_MDU = 1'b1
  } slow_src_e;

  slow_src_e       ptr_q, ptr_d;
  logic            lsu_prio;
  logic            slow_acc;
  logic [4:0]      slow_rd;
  logic            win_valid;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_res;
  logic [31:0]     busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= SRC_LSU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // After a slow transfer the other slow source gets priority next time both compete.
  always_comb begin
    ptr_d = ptr_q;
    if (lsu_ready) begin
      ptr_d = SRC_MDU;
    end else if (mdu_ready) begin
      ptr_d = SRC_LSU;
    end
  end

  // Grant: ALU always wins; ready is derived only from valids, pointer and reset.
  always_comb begin
    lsu_prio  = (RR_SLOW != 0) ? (ptr_q == SRC_LSU) : 1'b1;
    lsu_ready = 1'b0;
    mdu_ready = 1'b0;
    if (!rst && !alu_valid) begin
      lsu_ready = lsu_valid && (!mdu_valid || lsu_prio);
      mdu_ready = mdu_valid && (!lsu_valid || !lsu_prio);
    end
  end

  always_comb begin
    slow_acc  = lsu_ready || mdu_ready;
    slow_rd   = lsu_ready ? lsu_rd : mdu_rd;
    win_valid = 1'b0;
    win_rd    = '0;
    win_res   = '0;
    if (!rst && alu_valid) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_res   = alu_res;
    end else if (lsu_ready) begin
      win_valid = 1'b1;
      win_rd    = lsu_rd;
      win_res   = lsu_res;
    end else if (mdu_ready) begin
      win_valid = 1'b1;
      win_rd    = mdu_rd;
      win_res   = mdu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we  <= 1'b0;
      rd  <= '0;
      rrd <= '0;
    end else begin
      we <= win_valid && (win_rd != 5'd0);
      if (win_valid) begin
        rd  <= win_rd;
        rrd <= win_res;
      end
    end
  end

  // Clear on slow retirement, then set from issue so a same-cycle re-dispatch keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (slow_acc && (slow_rd != 5'd0)) begin
      busy_d[slow_rd] = 1'b0;
    end
    if (busy_set && (busy_rd != 5'd0)) begin
      busy_d[busy_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_rs1 = busy_q[q_rs1];
  assign busy_rs2 = busy_q[q_rs2];
  assign busy_qrd = busy_q[q_rd];

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback: a cycle-by-cycle vector table on the round-robin
// instance, plus arbitration sequences comparing round-robin and fixed-priority builds.
module tb_gpr_writeback;

  typedef struct {
    bit [31:0] rst, av, ard, ares, lv, lrd, lres, mv, mrd, mres, bs, brd, q1, q2, q3;
    bit [31:0] e_lr, e_mr, e_we, e_rd, e_rrd, e_b1, e_b2, e_b3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, mdu_valid, busy_set;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd, busy_rd, q_rs1, q_rs2, q_rd;
  logic [31:0] alu_res, lsu_res, mdu_res;

  logic        lsu_ready, mdu_ready, busy_rs1, busy_rs2, busy_qrd, we;
  logic [4:0]  rd;
  logic [31:0] rrd;
  logic        fp_lsu_ready, fp_mdu_ready, fp_busy_rs1, fp_busy_rs2, fp_busy_qrd, fp_we;
  logic [4:0]  fp_rd;
  logic [31:0] fp_rrd;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  gpr_writeback #(.XLEN(32), .RR_SLOW(1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_res(alu_res),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_res(lsu_res),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_res(mdu_res),
    .busy_set(busy_set), .busy_rd(busy_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_qrd(busy_qrd),
    .rd(rd), .rrd(rrd), .we(we)
  );

  gpr_writeback #(.XLEN(32), .RR_SLOW(0)) dut_fp (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_res(alu_res),
    .lsu_valid(lsu_valid), .lsu_ready(fp_lsu_ready), .lsu_rd(lsu_rd), .lsu_res(lsu_res),
    .mdu_valid(mdu_valid), .mdu_ready(fp_mdu_ready), .mdu_rd(mdu_rd), .mdu_res(mdu_res),
    .busy_set(busy_set), .busy_rd(busy_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .busy_rs1(fp_busy_rs1), .busy_rs2(fp_busy_rs2), .busy_qrd(fp_busy_qrd),
    .rd(fp_rd), .rrd(fp_rrd), .we(fp_we)
  );

  // Producer error: the issue stage queries q_rd with the ALU destination it is writing.
  always @(negedge clk) begin
    if (!rst && alu_valid && (q_rd == alu_rd) && (alu_rd != 5'd0)) begin
      assert (!busy_qrd) else $error("[TB] ALU write to busy register %0d", alu_rd);
    end
    if (we) begin
      assert (rd != 5'd0) else $error("[TB] write enable with rd=0");
    end
  end

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst[0];
    alu_valid = v.av[0];
    alu_rd    = v.ard[4:0];
    alu_res   = v.ares;
    lsu_valid = v.lv[0];
    lsu_rd    = v.lrd[4:0];
    lsu_res   = v.lres;
    mdu_valid = v.mv[0];
    mdu_rd    = v.mrd[4:0];
    mdu_res   = v.mres;
    busy_set  = v.bs[0];
    busy_rd   = v.brd[4:0];
    q_rs1     = v.q1[4:0];
    q_rs2     = v.q2[4:0];
    q_rd      = v.q3[4:0];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    vec_t z;
    z = '{default: 32'd0};
    applyStimulus(z);
  endtask

  initial begin
    // {rst,av,ard,ares, lv,lrd,lres, mv,mrd,mres, bs,brd, q1,q2,q3,
    //  e_lr,e_mr,e_we,e_rd,e_rrd, e_b1,e_b2,e_b3}
    vecs.push_back('{1,0,0,0, 1,3,32'h33, 1,4,32'h44, 0,0, 3,4,7, 0,0,0,0,0, 0,0,0});
    vecs.push_back('{0,1,5,32'h12345678, 1,6,32'hAAAA0006, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0, 0,0,0});
    vecs.push_back('{0,0,0,0, 1,6,32'hAAAA0006, 0,0,0, 0,0, 0,0,0, 1,0,1,5,32'h12345678, 0,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0, 0,0,0, 1,7, 7,0,0, 0,0,1,6,32'hAAAA0006, 0,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0, 1,7,32'hDEADBEEF, 0,0, 7,0,0, 0,1,0,6,32'hAAAA0006, 1,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0, 0,0,0, 0,0, 7,0,0, 0,0,1,7,32'hDEADBEEF, 0,0,0});
    vecs.push_back('{0,0,0,0, 1,0,32'hFFFFFFFF, 0,0,0, 0,0, 7,0,0, 1,0,0,7,32'hDEADBEEF, 0,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0, 0,0,0, 1,9, 0,9,0, 0,0,0,0,32'hFFFFFFFF, 0,0,0});
    vecs.push_back('{0,0,0,0, 1,9,32'h99, 0,0,0, 1,9, 0,9,0, 1,0,0,0,32'hFFFFFFFF, 0,1,0});
    vecs.push_back('{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,9,0, 0,0,1,9,32'h99, 0,1,0});
    vecs.push_back('{0,0,0,0, 0,0,0, 1,9,32'h909, 0,0, 0,9,9, 0,1,0,9,32'h99, 0,1,1});
    vecs.push_back('{0,0,0,0, 0,0,0, 0,0,0, 1,0, 0,9,9, 0,0,1,9,32'h909, 0,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,9,32'h909, 0,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0, 0,0,0, 1,12, 12,0,12, 0,0,0,9,32'h909, 0,0,0});
    vecs.push_back('{1,0,0,0, 0,0,0, 1,12,32'hBAD, 0,0, 12,0,12, 0,0,0,9,32'h909, 1,0,1});
    vecs.push_back('{0,0,0,0, 0,0,0, 0,0,0, 0,0, 12,0,12, 0,0,0,0,0, 0,0,0});
    vecs.push_back('{0,1,0,32'h55, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0, 0,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,32'h55, 0,0,0});

    idleInputs();
    rst = 1'b1;
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d lsu_ready", i), {31'd0, lsu_ready}, vecs[i].e_lr);
      checkOutput($sformatf("row%0d mdu_ready", i), {31'd0, mdu_ready}, vecs[i].e_mr);
      checkOutput($sformatf("row%0d we", i), {31'd0, we}, vecs[i].e_we);
      checkOutput($sformatf("row%0d rd", i), {27'd0, rd}, vecs[i].e_rd);
      checkOutput($sformatf("row%0d rrd", i), rrd, vecs[i].e_rrd);
      checkOutput($sformatf("row%0d busy_rs1", i), {31'd0, busy_rs1}, vecs[i].e_b1);
      checkOutput($sformatf("row%0d busy_rs2", i), {31'd0, busy_rs2}, vecs[i].e_b2);
      checkOutput($sformatf("row%0d busy_qrd", i), {31'd0, busy_qrd}, vecs[i].e_b3);
    end

    // Both slow sources held valid: alternating grants vs. LSU always winning.
    @(posedge clk);
    #1;
    idleInputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd1;
    lsu_res   = 32'h11;
    mdu_valid = 1'b1;
    mdu_rd    = 5'd2;
    mdu_res   = 32'h22;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr%0d lsu_ready", k), {31'd0, lsu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr%0d mdu_ready", k), {31'd0, mdu_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fp%0d lsu_ready", k), {31'd0, fp_lsu_ready}, 32'd1);
      checkOutput($sformatf("fp%0d mdu_ready", k), {31'd0, fp_mdu_ready}, 32'd0);
      if (k > 0) begin
        checkOutput($sformatf("rr%0d rd", k), {27'd0, rd}, (k % 2 == 1) ? 32'd1 : 32'd2);
        checkOutput($sformatf("fp%0d rd", k), {27'd0, fp_rd}, 32'd1);
      end
      @(posedge clk);
      #1;
    end
    idleInputs();
    @(negedge clk);
    checkOutput("rr last rrd", rrd, 32'h22);
    checkOutput("rr last we", {31'd0, we}, 32'd1);
    checkOutput("fp last rrd", fp_rrd, 32'h11);

    // ALU preempts both slow sources; the waiting LSU is taken the cycle after.
    @(posedge clk);
    #1;
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_res   = 32'hA1A1A1A1;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd4;
    lsu_res   = 32'h4444;
    @(negedge clk);
    checkOutput("alu pri lsu_ready", {31'd0, lsu_ready}, 32'd0);
    checkOutput("alu pri fp lsu_ready", {31'd0, fp_lsu_ready}, 32'd0);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    @(negedge clk);
    checkOutput("alu pri rrd", rrd, 32'hA1A1A1A1);
    checkOutput("lsu after alu ready", {31'd0, lsu_ready}, 32'd1);
    @(posedge clk);
    #1;
    idleInputs();
    @(negedge clk);
    checkOutput("lsu after alu rd", {27'd0, rd}, 32'd4);
    checkOutput("lsu after alu rrd", rrd, 32'h4444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
